// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single-port RAM: registered grant, round-robin on ties, MAX_HOLD preemption.
// Define MEM_ARB_FIXED_PRIO_EN to make M0 always win contention and be exempt from preemption.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t              state_reg, state_next;
    logic                last_owner_reg, last_owner_next;  // 0 = M0, 1 = M1
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic                rd_pend_reg;
    logic                rd_owner_reg;

    logic [1:0]          cmd_in [2];
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DATA_W-1:0]   rdata [2];
    logic                hold_full;
    logic                tie_to_m1;
    logic                preempt0;
    logic                preempt1;

    assign cmd_in[0] = m0_cmd;
    assign cmd_in[1] = m1_cmd;

    // Code 11 is not a request, so it can neither win arbitration nor reach the RAM.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign req[gi]    = (cmd_in[gi] == CMD_READ) || (cmd_in[gi] == CMD_WRITE);
        assign rvalid[gi] = rd_pend_reg && (rd_owner_reg == 1'(gi));
        assign rdata[gi]  = rvalid[gi] ? mem_rdata : '0;
    end

    assign gnt[0]    = (state_reg == OWN0);
    assign gnt[1]    = (state_reg == OWN1);
    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];
    assign m0_rdata  = rdata[0];
    assign m1_rdata  = rdata[1];

    assign hold_full = (hold_cnt_reg == HOLD_LAST);

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign tie_to_m1 = 1'b0;
    assign preempt0  = 1'b0;
`else
    assign tie_to_m1 = ~last_owner_reg;
    assign preempt0  = req[1] & hold_full;
`endif
    assign preempt1  = req[0] & hold_full;

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        hold_cnt_next   = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req[0] && req[1]) begin
                    state_next = tie_to_m1 ? OWN1 : OWN0;
                end else if (req[0]) begin
                    state_next = OWN0;
                end else if (req[1]) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                last_owner_next = 1'b0;
                if (!req[0]) begin
                    state_next = req[1] ? OWN1 : IDLE;
                end else if (preempt0) begin
                    state_next = OWN1;
                end
            end
            OWN1: begin
                last_owner_next = 1'b1;
                if (!req[1]) begin
                    state_next = req[0] ? OWN0 : IDLE;
                end else if (preempt1) begin
                    state_next = OWN0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Saturating run length of the current ownership stint.
        if ((state_next != state_reg) || (state_reg == IDLE)) begin
            hold_cnt_next = '0;
        end else if (!hold_full) begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
    end

    always_comb begin
        mem_cmd   = CMD_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_cmd   = req[0] ? m0_cmd : CMD_NONE;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt[1]) begin
            mem_cmd   = req[1] ? m1_cmd : CMD_NONE;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
            hold_cnt_reg   <= '0;
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            hold_cnt_reg   <= hold_cnt_next;
            rd_pend_reg    <= (mem_cmd == CMD_READ);
            rd_owner_reg   <= gnt[1];
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic against a cycle-level ownership model.
module tb_mem_bus_arbiter;

    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 16;
    localparam int MAX_HOLD = 4;
    localparam int DEPTH    = 1 << ADDR_W;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        c0, c1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] w0, w1;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m0_cmd(c0), .m0_addr(a0), .m0_wdata(w0),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_cmd(c1), .m1_addr(a1), .m1_wdata(w1),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // RAM driven only by the DUT's bus; shadow holds the contents the model expects
    logic [DATA_W-1:0] ram    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];
    logic              ram_load;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= shadow[i];
        end else begin
            if (mem_cmd == 2'b01) mem_rdata <= ram[mem_addr];
            if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
        end
    end

    // Model: owner 0 = nobody, 1 = M0, 2 = M1; run = cycles owned in current stint
    int              m_owner, m_run, m_last, m_rd_who;
    bit              m_rd_pend;
    logic [DATA_W-1:0] m_rd_data;
    bit              acc0, acc1;
    int              n_cmp = 0;
    int              n_err = 0;

    function automatic bit is_req(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = 0;
        m_run     = 0;
        m_last    = 2;
        m_rd_pend = 1'b0;
        m_rd_who  = 0;
        m_rd_data = '0;
    endtask

    // One bus cycle: predict, check mid-cycle, advance the model, end just after the next rising edge.
    task automatic cycle();
        bit r0, r1, eg0, eg1, erv0, erv1;
        logic [1:0]        ecmd;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] ewd, erd0, erd1;
        int nxt;
        r0 = is_req(c0);
        r1 = is_req(c1);
        eg0 = (m_owner == 1);
        eg1 = (m_owner == 2);
        ecmd = 2'b00; eaddr = '0; ewd = '0;
        if (eg0) begin ecmd = r0 ? c0 : 2'b00; eaddr = a0; ewd = w0; end
        if (eg1) begin ecmd = r1 ? c1 : 2'b00; eaddr = a1; ewd = w1; end
        erv0 = m_rd_pend && (m_rd_who == 1);
        erv1 = m_rd_pend && (m_rd_who == 2);
        erd0 = erv0 ? m_rd_data : '0;
        erd1 = erv1 ? m_rd_data : '0;
        @(negedge clk);
        chk("m0_gnt", 32'(m0_gnt), 32'(eg0));
        chk("m1_gnt", 32'(m1_gnt), 32'(eg1));
        chk("mem_cmd", 32'(mem_cmd), 32'(ecmd));
        chk("mem_addr", 32'(mem_addr), 32'(eaddr));
        chk("mem_wdata", 32'(mem_wdata), 32'(ewd));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(erv0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(erv1));
        chk("m0_rdata", 32'(m0_rdata), 32'(erd0));
        chk("m1_rdata", 32'(m1_rdata), 32'(erd1));
        acc0 = eg0 && r0;
        acc1 = eg1 && r1;
        m_rd_pend = (ecmd == 2'b01);
        m_rd_who  = m_owner;
        if (ecmd == 2'b01) m_rd_data = shadow[eaddr];
        if (ecmd == 2'b10) shadow[eaddr] = ewd;
        if (m_owner == 1 && r0 && !(!FIXED && r1 && m_run >= MAX_HOLD)) nxt = 1;
        else if (m_owner == 2 && r1 && !(r0 && m_run >= MAX_HOLD))     nxt = 2;
        else if (m_owner == 1)  nxt = r1 ? 2 : 0;
        else if (m_owner == 2)  nxt = r0 ? 1 : 0;
        else if (r0 && r1)      nxt = FIXED ? 1 : ((m_last == 1) ? 2 : 1);
        else                    nxt = r0 ? 1 : (r1 ? 2 : 0);
        if (m_owner != 0) m_last = m_owner;
        m_run   = (nxt != 0 && nxt == m_owner) ? m_run + 1 : ((nxt != 0) ? 1 : 0);
        m_owner = nxt;
        if (reset) model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic new_txn(output logic [1:0] c, output logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] w);
        int r;
        r = int'($urandom_range(0, 9));
        c = (r < 2) ? 2'b00 : (r == 2) ? 2'b11 : (r < 7) ? 2'b01 : 2'b10;
        a = ADDR_W'($urandom_range(0, 31));
        w = DATA_W'($urandom);
    endtask

    // Both masters request from IDLE; winner does one access then drops, loser follows with no idle gap.
    task automatic tie_test(input string tag, input int winner);
        c0 = 2'b01; a0 = ADDR_W'($urandom_range(0, 63));
        c1 = 2'b01; a1 = ADDR_W'($urandom_range(0, 63));
        cycle();
        chk({tag, "_first"}, 32'({m1_gnt, m0_gnt}), (winner == 1) ? 32'd1 : 32'd2);
        cycle();
        if (winner == 1) c0 = 2'b00; else c1 = 2'b00;
        cycle();
        chk({tag, "_second"}, 32'({m1_gnt, m0_gnt}), (winner == 1) ? 32'd2 : 32'd1);
        cycle();
        c0 = 2'b00; c1 = 2'b00;
        repeat (2) cycle();
    endtask

    initial begin
        int reads_done, m0_before;
        bit m1_seen;
        for (int i = 0; i < DEPTH; i++) shadow[i] = DATA_W'($urandom);
        shadow[5] = 16'hBEEF;
        reset = 1'b1; ram_load = 1'b1;
        c0 = 2'b01; a0 = '0; w0 = '0;
        c1 = 2'b10; a1 = '0; w1 = '0;
        @(posedge clk); #1;
        ram_load = 1'b0;
        model_reset();

        // T1: held in reset while both request
        repeat (3) cycle();

        // T2: single read of RAM[5]
        reset = 1'b0; c0 = 2'b00; c1 = 2'b00;
        cycle();
        c0 = 2'b01; a0 = 9'h005;
        cycle();
        chk("t2_gnt", 32'(m0_gnt), 32'd1);
        chk("t2_addr", 32'(mem_addr), 32'h005);
        cycle();
        c0 = 2'b00;
        chk("t2_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t2_rdata", 32'(m0_rdata), 32'hBEEF);
        repeat (2) cycle();

        // T3: tie after reset goes to M0, then a second tie still goes to M0
        reset = 1'b1; cycle(); reset = 1'b0;
        tie_test("t3", 1);
        tie_test("t3b", 1);
        // After a solo M0 access, a tie goes to M1 unless M0 has fixed priority
        c0 = 2'b01; a0 = 9'h007;
        cycle(); cycle();
        c0 = 2'b00;
        repeat (2) cycle();
        tie_test("t6_tie", FIXED ? 1 : 2);

        // T4/T5: M0 streams 6 reads while M1 waits with one write
        reset = 1'b1; cycle(); reset = 1'b0;
        reads_done = 0; m0_before = 0; m1_seen = 1'b0;
        c0 = 2'b01; a0 = 9'h020;
        c1 = 2'b10; a1 = 9'h010; w1 = 16'h1234;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (acc0) begin
                reads_done++;
                if (reads_done < 6) a0 = a0 + ADDR_W'(1); else c0 = 2'b00;
            end
            if (acc1) c1 = 2'b00;
            if (m1_gnt && !m1_seen) begin
                m1_seen = 1'b1;
                chk("t5_m0_rvalid", 32'(m0_rvalid), FIXED ? 32'd0 : 32'd1);
                chk("t5_m1_rvalid", 32'(m1_rvalid), 32'd0);
            end else if (m0_gnt && !m1_seen) begin
                m0_before++;
            end
        end
        chk("t4_m0_owned", 32'(m0_before), FIXED ? 32'd7 : 32'd4);
        chk("t4_reads", 32'(reads_done), 32'd6);
        chk("t4_ram", 32'(ram[16]), 32'h1234);

        // T6: reset lands on the cycle the read is issued
        c0 = 2'b01; a0 = 9'h005;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0; c0 = 2'b00;
        chk("t6_rvalid", 32'(m0_rvalid), 32'd0);
        chk("t6_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        cycle();

        // Random traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            if (acc0 || !is_req(c0)) new_txn(c0, a0, w0);
            if (acc1 || !is_req(c1)) new_txn(c1, a1, w1);
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
